snake_score_tracker: RTL and testbench



---
 rtl/snake_score_tracker_pkg.sv | 54 +++++
 rtl/snake_score_tracker_seg7_mux.sv | 64 ++++++
 rtl/snake_score_tracker.sv | 79 +++++++
 tb/tb_snake_score_tracker.sv | 349 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/snake_score_tracker_pkg.sv
// Shared definitions for the snake score tracker: master-state encodings common with the
// master state machine, active-low seven-segment patterns and BCD helpers.
package snake_score_tracker_pkg;

   typedef enum logic [1:0] {
      MS_IDLE   = 2'b00,
      MS_PLAY   = 2'b01,
      MS_WIN    = 2'b10,
      MS_UNUSED = 2'b11
   } master_state_e;

   // Segment order {dp,g,f,e,d,c,b,a}, active-low.
   localparam logic [7:0] SEG_0     = 8'hC0;
   localparam logic [7:0] SEG_1     = 8'hF9;
   localparam logic [7:0] SEG_2     = 8'hA4;
   localparam logic [7:0] SEG_3     = 8'hB0;
   localparam logic [7:0] SEG_4     = 8'h99;
   localparam logic [7:0] SEG_5     = 8'h92;
   localparam logic [7:0] SEG_6     = 8'h82;
   localparam logic [7:0] SEG_7     = 8'hF8;
   localparam logic [7:0] SEG_8     = 8'h80;
   localparam logic [7:0] SEG_9     = 8'h90;
   localparam logic [7:0] SEG_BLANK = 8'hFF;

   function automatic logic [7:0] seg7_decode(input logic [3:0] digit);
      logic [7:0] seg;
      case (digit)
         4'd0:    seg = SEG_0;
         4'd1:    seg = SEG_1;
         4'd2:    seg = SEG_2;
         4'd3:    seg = SEG_3;
         4'd4:    seg = SEG_4;
         4'd5:    seg = SEG_5;
         4'd6:    seg = SEG_6;
         4'd7:    seg = SEG_7;
         4'd8:    seg = SEG_8;
         4'd9:    seg = SEG_9;
         default: seg = SEG_BLANK;
      endcase
      return seg;
   endfunction

   // One BCD step; caller guarantees the input is below 99.
   function automatic logic [7:0] bcd_inc(input logic [7:0] bcd);
      logic [7:0] res;
      if (bcd[3:0] == 4'd9) begin
         res = {bcd[7:4] + 4'd1, 4'd0};
      end else begin
         res = {bcd[7:4], bcd[3:0] + 4'd1};
      end
      return res;
   endfunction

endpackage

// File: rtl/snake_score_tracker_seg7_mux.sv
// Four-digit multiplexed seven-segment driver: ones on digit 0, tens on digit 1, digits 2-3
// blank. Anode select and segment pattern are registered together.
module snake_score_tracker_seg7_mux
   import snake_score_tracker_pkg::*;
#(
   parameter int unsigned REFRESH_DIV = 100000
) (
   input  logic       clk_i,
   input  logic       rst_i,
   input  logic [7:0] score_bcd_i,
   output logic [3:0] seg_select_o,
   output logic [7:0] hex_out_o
);

   localparam int unsigned CntW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
   localparam logic [CntW-1:0] CntMax = CntW'(REFRESH_DIV - 1);

   logic [CntW-1:0] cnt_q, cnt_d;
   logic [1:0]      idx_q, idx_d;
   logic [3:0]      sel_q, sel_d;
   logic [7:0]      hex_q, hex_d;

   always_comb begin
      cnt_d = cnt_q + CntW'(1);
      idx_d = idx_q;
      if (cnt_q == CntMax) begin
         cnt_d = '0;
         idx_d = idx_q + 2'd1;
      end

      sel_d = 4'b1110;
      hex_d = SEG_BLANK;
      unique case (idx_q)
         2'd0: begin
            sel_d = 4'b1110;
            hex_d = seg7_decode(score_bcd_i[3:0]);
         end
         2'd1: begin
            sel_d = 4'b1101;
            hex_d = seg7_decode(score_bcd_i[7:4]);
         end
         2'd2: sel_d = 4'b1011;
         2'd3: sel_d = 4'b0111;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         cnt_q <= '0;
         idx_q <= 2'd0;
         sel_q <= 4'b1110;
         hex_q <= SEG_BLANK;
      end else begin
         cnt_q <= cnt_d;
         idx_q <= idx_d;
         sel_q <= sel_d;
         hex_q <= hex_d;
      end
   end

   assign seg_select_o = sel_q;
   assign hex_out_o    = hex_q;

endmodule

// File: rtl/snake_score_tracker.sv
// Snake score tracker: counts target-reached rising edges in PLAY as a 2-digit BCD score and
// raises a sticky GAME_WON. Define SCORE_DISPLAY_EN to build the seven-segment display driver.
module snake_score_tracker
   import snake_score_tracker_pkg::*;
#(
   parameter int unsigned WIN_SCORE   = 10,
   parameter int unsigned REFRESH_DIV = 100000
) (
   input  logic       CLK,
   input  logic       RESET,
   input  logic [1:0] MASTER_STATE,
   input  logic       TARGET_REACHED,
   output logic       GAME_WON,
   output logic [7:0] SCORE_BCD,
   output logic [3:0] SEG_SELECT,
   output logic [7:0] HEX_OUT
);

   localparam logic [7:0] WinBcd = {4'(WIN_SCORE / 10), 4'(WIN_SCORE % 10)};

   logic       prev_q, prev_d;
   logic [7:0] score_q, score_d;
   logic       won_q, won_d;
   logic       inc;

   always_comb begin
      prev_d  = TARGET_REACHED;
      inc     = TARGET_REACHED & ~prev_q;
      score_d = score_q;
      won_d   = won_q;
      case (MASTER_STATE)
         MS_PLAY: begin
            if (inc && !won_q && (score_q != 8'h99)) begin
               score_d = bcd_inc(score_q);
               won_d   = (score_d == WinBcd);
            end
         end
         MS_WIN: ;
         // IDLE and the unused encoding clear the game, overriding any increment.
         default: begin
            score_d = 8'h00;
            won_d   = 1'b0;
         end
      endcase
   end

   always_ff @(posedge CLK) begin
      if (RESET) begin
         prev_q  <= 1'b0;
         score_q <= 8'h00;
         won_q   <= 1'b0;
      end else begin
         prev_q  <= prev_d;
         score_q <= score_d;
         won_q   <= won_d;
      end
   end

   assign SCORE_BCD = score_q;
   assign GAME_WON  = won_q;

`ifdef SCORE_DISPLAY_EN
   snake_score_tracker_seg7_mux #(
      .REFRESH_DIV (REFRESH_DIV)
   ) u_seg7_mux (
      .clk_i        (CLK),
      .rst_i        (RESET),
      .score_bcd_i  (score_q),
      .seg_select_o (SEG_SELECT),
      .hex_out_o    (HEX_OUT)
   );
`else
   logic unused_refresh_div;
   assign unused_refresh_div = ^REFRESH_DIV;
   assign SEG_SELECT = 4'b1111;
   assign HEX_OUT    = SEG_BLANK;
`endif

endmodule

// File: tb/tb_snake_score_tracker.sv
// Bench for snake_score_tracker: two instances (WIN_SCORE 10 and 99) driven in lockstep,
// expected outputs queued per cycle from a binary-count model and compared one edge later.
module tb_snake_score_tracker;

   logic       CLK = 1'b0;
   logic       RESET;
   logic [1:0] ms0, ms1;
   logic       tg0, tg1;
   logic       won0, won1;
   logic [7:0] score0, score1;
   logic [3:0] sel0, sel1;
   logic [7:0] hex0, hex1;

   always #5 CLK = ~CLK;

   snake_score_tracker #(
      .WIN_SCORE   (10),
      .REFRESH_DIV (4)
   ) dut0 (
      .CLK            (CLK),
      .RESET          (RESET),
      .MASTER_STATE   (ms0),
      .TARGET_REACHED (tg0),
      .GAME_WON       (won0),
      .SCORE_BCD      (score0),
      .SEG_SELECT     (sel0),
      .HEX_OUT        (hex0)
   );

   snake_score_tracker #(
      .WIN_SCORE   (99),
      .REFRESH_DIV (4)
   ) dut1 (
      .CLK            (CLK),
      .RESET          (RESET),
      .MASTER_STATE   (ms1),
      .TARGET_REACHED (tg1),
      .GAME_WON       (won1),
      .SCORE_BCD      (score1),
      .SEG_SELECT     (sel1),
      .HEX_OUT        (hex1)
   );

   typedef struct packed {
      logic [7:0] s0;
      logic       w0;
      logic [7:0] s1;
      logic       w1;
   } exp_t;

   exp_t sb_q[$];
   exp_t e;
   int   n_cmp = 0;
   int   n_err = 0;

   int m_s0, m_s1;
   bit m_w0, m_w1, m_p0, m_p1;

   localparam logic [1:0] IDLE = 2'b00, PLAY = 2'b01, WIN = 2'b10, UNUSED = 2'b11;

   task automatic model_step(input logic r, input logic [1:0] st, input logic t, input int win,
                             inout int s, inout bit w, inout bit p);
      bit inc;
      inc = t && !p;
      if (r) begin
         s = 0;
         w = 0;
         p = 0;
      end else begin
         if (st == PLAY) begin
            if (inc && !w && s != 99) begin
               s = s + 1;
               w = (s == win);
            end
         end else if (st != WIN) begin
            s = 0;
            w = 0;
         end
         p = t;
      end
   endtask

   function automatic logic [7:0] to_bcd(input int v);
      return 8'(((v / 10) << 4) | (v % 10));
   endfunction

   // Drive one cycle of stimulus on the falling edge and queue the expected result.
   task automatic cycle(input logic r, input logic [1:0] st0, input logic t0,
                        input logic [1:0] st1, input logic t1);
      exp_t x;
      @(negedge CLK);
      RESET = r;
      ms0 = st0;
      tg0 = t0;
      ms1 = st1;
      tg1 = t1;
      model_step(r, st0, t0, 10, m_s0, m_w0, m_p0);
      model_step(r, st1, t1, 99, m_s1, m_w1, m_p1);
      x.s0 = to_bcd(m_s0);
      x.w0 = m_w0;
      x.s1 = to_bcd(m_s1);
      x.w1 = m_w1;
      sb_q.push_back(x);
   endtask

   task automatic test_reset;
      for (int i = 0; i < 2; i++) begin
         cycle(1'b1, IDLE, 1'b0, IDLE, 1'b0);
         @(posedge CLK); #1;
         e = sb_q.pop_front();
         n_cmp++;
         if ({score0, won0, score1, won1} !== e) begin
            n_err++;
            $display("FAIL reset_state: got %h %b %h %b want %h %b %h %b",
                     score0, won0, score1, won1, e.s0, e.w0, e.s1, e.w1);
         end
      end
      n_cmp++;
`ifdef SCORE_DISPLAY_EN
      if (sel0 !== 4'b1110 || hex0 !== 8'hFF) begin
`else
      if (sel0 !== 4'b1111 || hex0 !== 8'hFF) begin
`endif
         n_err++;
         $display("FAIL reset_display: got sel=%b hex=%h", sel0, hex0);
      end
      cycle(1'b0, PLAY, 1'b0, IDLE, 1'b0);
      @(posedge CLK); #1;
      e = sb_q.pop_front();
      n_cmp++;
      if ({score0, won0, score1, won1} !== e) begin
         n_err++;
         $display("FAIL play_idle: got %h %b %h %b want %h %b %h %b",
                  score0, won0, score1, won1, e.s0, e.w0, e.s1, e.w1);
      end
      n_cmp++;
`ifdef SCORE_DISPLAY_EN
      if (sel0 !== 4'b1110 || hex0 !== 8'hC0) begin
         $display("FAIL first_refresh: got sel=%b hex=%h want 1110 c0", sel0, hex0);
`else
      if (sel0 !== 4'b1111 || hex0 !== 8'hFF) begin
         $display("FAIL first_refresh: got sel=%b hex=%h want 1111 ff", sel0, hex0);
`endif
         n_err++;
      end
   endtask

   task automatic test_level_hold;
      for (int i = 0; i < 52; i++) begin
         cycle(1'b0, PLAY, (i < 50), IDLE, 1'b0);
         @(posedge CLK); #1;
         e = sb_q.pop_front();
         n_cmp++;
         if ({score0, won0, score1, won1} !== e) begin
            n_err++;
            $display("FAIL level_hold[%0d]: got %h %b %h %b want %h %b %h %b", i,
                     score0, won0, score1, won1, e.s0, e.w0, e.s1, e.w1);
         end
      end
      n_cmp++;
      if (score0 !== 8'h01) begin
         n_err++;
         $display("FAIL level_hold_final: got %h want 01", score0);
      end
   endtask

   task automatic test_win10;
      cycle(1'b0, IDLE, 1'b0, IDLE, 1'b0);
      @(posedge CLK); #1;
      void'(sb_q.pop_front());
      // 11 pulses in PLAY, then 2 pulses in WIN.
      for (int i = 0; i < 26; i++) begin
         cycle(1'b0, (i < 22) ? PLAY : WIN, (i % 2 == 0), IDLE, 1'b0);
         @(posedge CLK); #1;
         e = sb_q.pop_front();
         n_cmp++;
         if ({score0, won0, score1, won1} !== e) begin
            n_err++;
            $display("FAIL win10[%0d]: got %h %b %h %b want %h %b %h %b", i,
                     score0, won0, score1, won1, e.s0, e.w0, e.s1, e.w1);
         end
         if (i == 18) begin
            n_cmp++;
            if (score0 !== 8'h10 || won0 !== 1'b1) begin
               n_err++;
               $display("FAIL win10_edge: got %h %b want 10 1", score0, won0);
            end
         end
      end
      n_cmp++;
      if (score0 !== 8'h10 || won0 !== 1'b1) begin
         n_err++;
         $display("FAIL win10_hold: got %h %b want 10 1", score0, won0);
      end
   endtask

   task automatic test_idle_clear;
      for (int k = 0; k < 2; k++) begin
         cycle(1'b0, IDLE, 1'b0, IDLE, 1'b0);
         @(posedge CLK); #1;
         void'(sb_q.pop_front());
         for (int i = 0; i < 11; i++) begin
            // Five pulses to reach 05, then a rising edge together with the leave to IDLE/11.
            if (i < 10) cycle(1'b0, PLAY, (i % 2 == 0), IDLE, 1'b0);
            else        cycle(1'b0, (k == 0) ? IDLE : UNUSED, 1'b1, IDLE, 1'b0);
            @(posedge CLK); #1;
            e = sb_q.pop_front();
            n_cmp++;
            if ({score0, won0, score1, won1} !== e) begin
               n_err++;
               $display("FAIL idle_clear%0d[%0d]: got %h %b %h %b want %h %b %h %b", k, i,
                        score0, won0, score1, won1, e.s0, e.w0, e.s1, e.w1);
            end
         end
         n_cmp++;
         if (score0 !== 8'h00 || won0 !== 1'b0) begin
            n_err++;
            $display("FAIL idle_clear%0d_final: got %h %b want 00 0", k, score0, won0);
         end
      end
   endtask

   task automatic test_reset_midgame;
      cycle(1'b0, IDLE, 1'b0, IDLE, 1'b0);
      @(posedge CLK); #1;
      void'(sb_q.pop_front());
      for (int i = 0; i < 8; i++) begin
         cycle((i == 7), PLAY, (i % 2 == 0), PLAY, (i % 2 == 0));
         @(posedge CLK); #1;
         e = sb_q.pop_front();
         n_cmp++;
         if ({score0, won0, score1, won1} !== e) begin
            n_err++;
            $display("FAIL reset_midgame[%0d]: got %h %b %h %b want %h %b %h %b", i,
                     score0, won0, score1, won1, e.s0, e.w0, e.s1, e.w1);
         end
      end
      n_cmp++;
      if (score0 !== 8'h00 || score1 !== 8'h00) begin
         n_err++;
         $display("FAIL reset_midgame_final: got %h %h want 00 00", score0, score1);
      end
   endtask

   task automatic test_bcd99;
      cycle(1'b0, IDLE, 1'b0, IDLE, 1'b0);
      @(posedge CLK); #1;
      void'(sb_q.pop_front());
      for (int i = 0; i < 204; i++) begin
         cycle(1'b0, IDLE, 1'b0, PLAY, (i % 2 == 0));
         @(posedge CLK); #1;
         e = sb_q.pop_front();
         n_cmp++;
         if ({score0, won0, score1, won1} !== e) begin
            n_err++;
            $display("FAIL bcd99[%0d]: got %h %b %h %b want %h %b %h %b", i,
                     score0, won0, score1, won1, e.s0, e.w0, e.s1, e.w1);
         end
         if (i == 16 || i == 18) begin
            n_cmp++;
            if (score1 !== ((i == 16) ? 8'h09 : 8'h10)) begin
               n_err++;
               $display("FAIL bcd_wrap[%0d]: got %h", i, score1);
            end
         end
      end
      n_cmp++;
      if (score1 !== 8'h99 || won1 !== 1'b1) begin
         n_err++;
         $display("FAIL bcd99_sat: got %h %b want 99 1", score1, won1);
      end
   endtask

   task automatic test_display;
      logic [3:0] sel_tab [4];
      logic [7:0] hex_tab [4];
      logic [3:0] last;
      bit         found;
      sel_tab = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
      hex_tab = '{8'hF8, 8'hB0, 8'hFF, 8'hFF};
      cycle(1'b0, IDLE, 1'b0, IDLE, 1'b0);
      @(posedge CLK); #1;
      void'(sb_q.pop_front());
      for (int i = 0; i < 74; i++) begin
         cycle(1'b0, IDLE, 1'b0, PLAY, (i % 2 == 0));
         @(posedge CLK); #1;
         e = sb_q.pop_front();
         n_cmp++;
         if ({score0, won0, score1, won1} !== e) begin
            n_err++;
            $display("FAIL display_setup[%0d]: got %h %b %h %b want %h %b %h %b", i,
                     score0, won0, score1, won1, e.s0, e.w0, e.s1, e.w1);
         end
      end
`ifdef SCORE_DISPLAY_EN
      found = 0;
      last  = sel1;
      for (int i = 0; i < 24 && !found; i++) begin
         @(posedge CLK); #1;
         if (sel1 === 4'b1101 && last !== 4'b1101) found = 1;
         else last = sel1;
      end
      n_cmp++;
      if (!found) begin
         n_err++;
         $display("FAIL display_sync: no tens digit select within 24 cycles, sel=%b", sel1);
      end else begin
         for (int k = 0; k < 16; k++) begin
            if (k != 0) begin
               @(posedge CLK); #1;
            end
            n_cmp++;
            if (sel1 !== sel_tab[(k / 4 + 1) % 4] || hex1 !== hex_tab[(k / 4 + 1) % 4]) begin
               n_err++;
               $display("FAIL display[%0d]: got sel=%b hex=%h want sel=%b hex=%h", k, sel1,
                        hex1, sel_tab[(k / 4 + 1) % 4], hex_tab[(k / 4 + 1) % 4]);
            end
         end
      end
`else
      for (int k = 0; k < 16; k++) begin
         @(posedge CLK); #1;
         n_cmp++;
         if (sel1 !== 4'b1111 || hex1 !== 8'hFF) begin
            n_err++;
            $display("FAIL display_off[%0d]: got sel=%b hex=%h want 1111 ff", k, sel1, hex1);
         end
      end
`endif
   endtask

   initial begin
      RESET = 1'b1;
      ms0 = IDLE;
      ms1 = IDLE;
      tg0 = 1'b0;
      tg1 = 1'b0;
      test_reset();
      test_level_hold();
      test_win10();
      test_idle_clear();
      test_reset_midgame();
      test_bcd99();
      test_display();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
